ecc_scrub_ctrl: RTL and testbench

Sequential scrub controller for the 32-bit single-error-correcting corrector (32 data, 8 check, `Gr` enable). It walks every word of a 40-bit-wide memory and routes each word through the corrector. Words whose corrected data differs from the stored data are written back, and corrections are counted. It sits between one memory port and the combinational corrector. Host traffic has priority on that port through a request/grant handshake.

---
 rtl/ecc_scrub_pkg.sv | 33 +++
 rtl/ecc_scrub_if.sv | 51 +++++
 rtl/ecc_scrub_errcnt.sv | 34 +++
 rtl/ecc_scrub_ctrl.sv | 144 ++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_scrub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_scrub_pkg
//  Description : Shared constants, FSM state type and codeword field helpers
//                for the ECC scrub controller.
//  Contents    : DW/CBW/WW widths, scrub_state_t, word_data(), word_chk()
//  Revision    : 1.0 - initial release
// ============================================================================
package ecc_scrub_pkg;

   localparam int DW  = 32;            // data bits per word
   localparam int CBW = 8;             // check bits per word
   localparam int WW  = DW + CBW;      // stored word width

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_CHECK   = 3'd3,
      S_WR_REQ  = 3'd4,
      S_NEXT    = 3'd5
   } scrub_state_t;

   function automatic logic [DW-1:0] word_data(input logic [WW-1:0] w);
      return w[DW-1:0];
   endfunction

   function automatic logic [CBW-1:0] word_chk(input logic [WW-1:0] w);
      return w[WW-1:DW];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_scrub_if.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_scrub_if
//  Description : Control, memory-port and corrector signals of the scrub
//                controller bundled in one interface.
//  Modports    : master - controller side (drives req/addr/cor_*/status)
//                slave  - environment side (memory port, corrector, host)
//  Signals     : start, stop, busy, done, err_cnt, mem_req, mem_we,
//                mem_addr, mem_wdata, mem_gnt, mem_rvalid, mem_rdata,
//                cor_id, cor_ic, cor_r, cor_od
//  Revision    : 1.0 - initial release
// ============================================================================
interface ecc_scrub_if #(
   parameter int AW = 8,
   parameter int CW = 16
);
   import ecc_scrub_pkg::*;

   logic           start;
   logic           stop;
   logic           busy;
   logic           done;
   logic [CW-1:0]  err_cnt;

   logic           mem_req;
   logic           mem_we;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_wdata;
   logic           mem_gnt;
   logic           mem_rvalid;
   logic [WW-1:0]  mem_rdata;

   logic [DW-1:0]  cor_id;
   logic [CBW-1:0] cor_ic;
   logic           cor_r;
   logic [DW-1:0]  cor_od;

   modport master (
      input  start, stop, mem_gnt, mem_rvalid, mem_rdata, cor_od,
      output busy, done, err_cnt, mem_req, mem_we, mem_addr, mem_wdata,
             cor_id, cor_ic, cor_r
   );

   modport slave (
      output start, stop, mem_gnt, mem_rvalid, mem_rdata, cor_od,
      input  busy, done, err_cnt, mem_req, mem_we, mem_addr, mem_wdata,
             cor_id, cor_ic, cor_r
   );

endinterface
`default_nettype wire

// File: rtl/ecc_scrub_errcnt.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_scrub_errcnt
//  Description : CW-bit saturating event counter with synchronous clear.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                i_clr     - clear to zero (wins over i_inc)
//                i_inc     - increment by one, holds at all-ones
//                o_cnt     - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module ecc_scrub_errcnt #(
   parameter int CW = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          i_clr,
   input  wire logic          i_inc,
   output logic [CW-1:0]      o_cnt
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {CW{1'b1}})) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ecc_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_scrub_ctrl
//  Description : Sequential ECC scrubber. Reads every word of a 2^AW-deep,
//                40-bit memory, passes it through an external SEC corrector
//                and writes back words whose corrected data differs.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - ecc_scrub_if.master (host control, memory port,
//                       corrector connection, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module ecc_scrub_ctrl #(
   parameter int AW = 8,
   parameter int CW = 16
) (
   input  wire logic    clk,
   input  wire logic    rst,
   ecc_scrub_if.master  bus
);
   import ecc_scrub_pkg::*;

   scrub_state_t   r_state;
   scrub_state_t   w_next;

   logic [AW-1:0]  r_addr;
   logic [WW-1:0]  r_word;
   logic [DW-1:0]  r_wdata;
   logic           r_we;
   logic           r_done;
   logic           r_stop;

   logic           w_cnt_clr;
   logic           w_cnt_inc;
   logic           w_mismatch;
   logic           w_last;
   logic           w_stop_eff;

   // The corrector sees only the registered word, so this compare is the
   // single combinational path through the block.
   assign w_mismatch = (bus.cor_od != word_data(r_word));
   assign w_last     = (r_addr == {AW{1'b1}});
   // A stop arriving in NEXT itself ends the sweep at this word.
   assign w_stop_eff = r_stop | bus.stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_cnt_clr = 1'b0;
      w_cnt_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next    = S_RD_REQ;
               w_cnt_clr = 1'b1;
            end
         end
         S_RD_REQ:  if (bus.mem_gnt)    w_next = S_RD_WAIT;
         S_RD_WAIT: if (bus.mem_rvalid) w_next = S_CHECK;
         S_CHECK: begin
            if (w_mismatch) begin
               w_next    = S_WR_REQ;
               w_cnt_inc = 1'b1;
            end else begin
               w_next = S_NEXT;
            end
         end
         S_WR_REQ:  if (bus.mem_gnt)    w_next = S_NEXT;
         S_NEXT:    w_next = (w_stop_eff || w_last) ? S_IDLE : S_RD_REQ;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_word  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_stop  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_addr <= '0;
                  r_we   <= 1'b0;
                  r_stop <= bus.stop;
               end
            end
            S_RD_WAIT: begin
               if (bus.mem_rvalid) r_word <= bus.mem_rdata;
            end
            S_CHECK: begin
               if (w_mismatch) begin
                  r_wdata <= bus.cor_od;
                  r_we    <= 1'b1;
               end
            end
            S_NEXT: begin
               if (!w_stop_eff) begin
                  if (w_last) begin
                     r_done <= 1'b1;
                  end else begin
                     r_addr <= r_addr + AW'(1);
                     r_we   <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
         // Sticky: the word in flight still completes, incl. write-back.
         if ((r_state != S_IDLE) && bus.stop) r_stop <= 1'b1;
      end
   end

   ecc_scrub_errcnt #(.CW(CW)) u_errcnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_cnt_clr),
      .i_inc (w_cnt_inc),
      .o_cnt (bus.err_cnt)
   );

   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = r_done;
   assign bus.mem_req   = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.cor_id    = word_data(r_word);
   assign bus.cor_ic    = word_chk(r_word);
   assign bus.cor_r     = bus.busy;

endmodule
`default_nettype wire

// File: tb/tb_ecc_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecc_scrub_ctrl
//  Description : Self-checking bench for ecc_scrub_ctrl. Provides a memory
//                port model with programmable grant delay, a behavioural SEC
//                corrector, and a sweep-level reference model that predicts
//                write-backs, error count, done and sweep duration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_scrub_ctrl;
   import ecc_scrub_pkg::*;

   localparam int AW  = 4;
   localparam int CW  = 3;
   localparam int NW  = 1 << AW;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ecc_scrub_if #(.AW(AW), .CW(CW)) bus ();

   ecc_scrub_ctrl #(.AW(AW), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- SEC code: distinct non-unit 8-bit columns -------------
   function automatic logic [7:0] col(input int i);
      int n = 0;
      for (int v = 3; v < 256; v++) begin
         if ((v & (v - 1)) != 0) begin
            if (n == i) return 8'(v);
            n++;
         end
      end
      return 8'h00;
   endfunction

   function automatic logic [7:0] enc(input logic [31:0] d);
      logic [7:0] c = 8'h00;
      for (int i = 0; i < 32; i++) if (d[i]) c = c ^ col(i);
      return c;
   endfunction

   function automatic logic [31:0] corr(input logic [31:0] d, input logic [7:0] c);
      logic [7:0]  s = enc(d) ^ c;
      logic [31:0] r = d;
      for (int i = 0; i < 32; i++) if ((s != 8'h00) && (col(i) == s)) r[i] = ~r[i];
      return r;
   endfunction

   assign bus.cor_od = bus.cor_r ? corr(bus.cor_id, bus.cor_ic) : bus.cor_id;

   // ---------------- memory port model ----------------
   typedef struct {int addr; logic [31:0] data;} wr_t;

   logic [39:0] mem [NW];
   logic [39:0] img [NW];
   logic        load = 1'b0;
   int          rd_wait = 0;
   int          wr_wait = 0;
   int          wait_cnt;
   logic        rv;
   logic [39:0] rv_data;
   int          rv_addr;
   wr_t         wlog[$];

   assign bus.mem_gnt    = bus.mem_req && (wait_cnt >= (bus.mem_we ? wr_wait : rd_wait));
   assign bus.mem_rvalid = rv;
   assign bus.mem_rdata  = rv_data;

   always @(posedge clk) begin
      if (load) for (int i = 0; i < NW; i++) mem[i] <= img[i];
      if (rst) begin
         wait_cnt <= 0;
         rv       <= 1'b0;
      end else begin
         rv <= 1'b0;
         if (bus.mem_req && bus.mem_gnt) begin
            wait_cnt <= 0;
            if (bus.mem_we) begin
               mem[bus.mem_addr] <= {enc(bus.mem_wdata), bus.mem_wdata};
               wlog.push_back('{int'(bus.mem_addr), bus.mem_wdata});
            end else begin
               rv      <= 1'b1;
               rv_data <= mem[bus.mem_addr];
               rv_addr <= int'(bus.mem_addr);
            end
         end else if (bus.mem_req) begin
            wait_cnt <= wait_cnt + 1;
         end
      end
   end

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   logic [31:0] clean [NW];

   task automatic make_clean();
      for (int i = 0; i < NW; i++) begin
         clean[i] = $urandom;
         img[i]   = {enc(clean[i]), clean[i]};
      end
   endtask

   task automatic load_img();
      @(negedge clk);
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   // Runs one sweep from start and compares against the sweep-level model.
   task automatic run_sweep(input string name, input int stop_at);
      wr_t         exp_w[$];
      int          base, last, n_fix, exp_cyc, cyc;
      bit          saw_done, hit, p_req, p_gnt, p_we, exp_done;
      logic [3:0]  p_addr;
      logic [31:0] p_wdata, d, cd;

      base     = wlog.size();
      last     = (stop_at < 0) ? NW - 1 : stop_at;
      exp_done = (stop_at < 0);
      n_fix    = 0;
      exp_cyc  = 0;
      for (int a = 0; a <= last; a++) begin
         d  = mem[a][31:0];
         cd = corr(d, mem[a][39:32]);
         exp_cyc += 4 + rd_wait;
         if (cd != d) begin
            exp_w.push_back('{a, cd});
            n_fix++;
            exp_cyc += 1 + wr_wait;
         end
      end

      @(negedge clk);
      bus.start = 1'b1;
      cyc = 0; saw_done = 0; hit = 0; p_req = 0; p_gnt = 0;
      p_we = 0; p_addr = '0; p_wdata = '0;
      forever begin
         @(negedge clk);
         bus.start = 1'b0;
         cyc++;
         if (cyc == 1) check({name, "_first_addr"}, bus.mem_addr, 0);
         bus.stop = hit;
         hit = (stop_at >= 0) && bus.mem_rvalid && (rv_addr == stop_at);
         if (p_req && !p_gnt) begin
            check({name, "_hold_req"},   bus.mem_req,   1);
            check({name, "_hold_addr"},  bus.mem_addr,  p_addr);
            check({name, "_hold_we"},    bus.mem_we,    p_we);
            check({name, "_hold_wdata"}, bus.mem_wdata, p_wdata);
         end
         p_req = bus.mem_req; p_gnt = bus.mem_gnt; p_addr = bus.mem_addr;
         p_we = bus.mem_we; p_wdata = bus.mem_wdata;
         if (bus.done) saw_done = 1;
         if (!bus.busy) break;
         if (cyc > 3000) begin
            check({name, "_timeout"}, 1, 0);
            break;
         end
      end
      bus.stop = 1'b0;

      check({name, "_cycles"},  cyc - 1, exp_cyc);
      check({name, "_done"},    saw_done, exp_done);
      check({name, "_err_cnt"}, bus.err_cnt, (n_fix > SAT) ? SAT : n_fix);
      check({name, "_nwrites"}, wlog.size() - base, exp_w.size());
      check({name, "_addr_hold"}, bus.mem_addr, last);
      for (int i = 0; i < exp_w.size(); i++) begin
         if (base + i < wlog.size()) begin
            check({name, "_wr_addr"}, wlog[base + i].addr, exp_w[i].addr);
            check({name, "_wr_data"}, wlog[base + i].data, exp_w[i].data);
         end
      end
      @(negedge clk);
      check({name, "_done_pulse"}, bus.done, 0);
   endtask

   initial begin
      int k;
      bus.start = 1'b0;
      bus.stop  = 1'b0;

      // ---- reset values ----
      repeat (3) @(negedge clk);
      check("rst_busy",    bus.busy,      0);
      check("rst_done",    bus.done,      0);
      check("rst_req",     bus.mem_req,   0);
      check("rst_we",      bus.mem_we,    0);
      check("rst_addr",    bus.mem_addr,  0);
      check("rst_wdata",   bus.mem_wdata, 0);
      check("rst_cor_id",  bus.cor_id,    0);
      check("rst_cor_ic",  bus.cor_ic,    0);
      check("rst_cor_r",   bus.cor_r,     0);
      check("rst_err_cnt", bus.err_cnt,   0);
      rst = 1'b0;

      // ---- clean sweep, ideal port: 64 cycles, no writes ----
      make_clean();
      load_img();
      run_sweep("clean", -1);

      // ---- single data flip at addr 5 bit 17, then re-sweep ----
      img[5][17] = ~img[5][17];
      load_img();
      run_sweep("flip5", -1);
      check("flip5_mem", mem[5], {enc(clean[5]), clean[5]});
      run_sweep("reread", -1);

      // ---- read grant withheld 3 cycles: 7*16 cycles ----
      make_clean();
      load_img();
      rd_wait = 3;
      run_sweep("slowgnt", -1);
      rd_wait = 0;

      // ---- every word flipped: counter saturates, 16 writes ----
      for (int i = 0; i < NW; i++) img[i][$urandom_range(31, 0)] ^= 1'b1;
      load_img();
      run_sweep("sat", -1);
      check("sat_cnt", bus.err_cnt, SAT);

      // ---- stop in CHECK of addr 9 with an error there ----
      make_clean();
      for (int i = 0; i < NW; i++) if ($urandom_range(1, 0) == 1) img[i][$urandom_range(31, 0)] ^= 1'b1;
      img[9][3] ^= 1'b1;
      load_img();
      run_sweep("stop9", 9);

      // ---- reset while a write-back waits for grant ----
      make_clean();
      img[2][20] ^= 1'b1;
      load_img();
      wr_wait = 50;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!(bus.mem_req && bus.mem_we) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("rstwr_reached", bus.mem_req && bus.mem_we, 1);
      k = wlog.size();
      rst = 1'b1;
      @(negedge clk);
      check("rstwr_busy",  bus.busy,      0);
      check("rstwr_req",   bus.mem_req,   0);
      check("rstwr_we",    bus.mem_we,    0);
      check("rstwr_addr",  bus.mem_addr,  0);
      check("rstwr_wdata", bus.mem_wdata, 0);
      check("rstwr_cor",   {bus.cor_ic, bus.cor_id}, 0);
      check("rstwr_cnt",   bus.err_cnt,   0);
      check("rstwr_nowr",  wlog.size(),   k);
      rst = 1'b0;
      wr_wait = 0;
      run_sweep("restart", -1);

      // ---- randomized sweeps ----
      for (int t = 0; t < 4; t++) begin
         make_clean();
         for (int i = 0; i < NW; i++) if ($urandom_range(2, 0) == 0) img[i][$urandom_range(39, 0)] ^= 1'b1;
         load_img();
         rd_wait = $urandom_range(2, 0);
         wr_wait = $urandom_range(2, 0);
         run_sweep("rand", ($urandom_range(1, 0) == 1) ? int'($urandom_range(NW - 1, 0)) : -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
